// File: rtl/vector_unit_pkg.sv
// rtl/vector_unit_pkg.sv - shared types and helpers for the packed-SIMD vector unit
package vector_unit_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        BIT8  = 2'd0,
        BIT16 = 2'd1,
        BIT32 = 2'd2
    } vesize_t;

    typedef enum logic [1:0] {
        VADD     = 2'd0,
        HV_VADD  = 2'd1,
        SAT_VADD = 2'd2
    } vadd_op_t;

    // Number of 8-bit slices that make up one lane; the unused encoding behaves as 32-bit.
    function automatic int lane_slices(input vesize_t e);
        case (e)
            BIT8:    return 1;
            BIT16:   return 2;
            default: return 32 / SLICE_W;
        endcase
    endfunction

endpackage

// File: rtl/simd_add_slice.sv
// rtl/simd_add_slice.sv - 8-bit add/subtract slice with carry chain and operand extension parity
module simd_add_slice
    import vector_unit_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               sub_i,
    input  logic               signed_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o,
    output logic               ext_o
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W:0]   total;

    assign b_eff  = sub_i ? ~b_i : b_i;
    assign total  = {1'b0, a_i} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin_i};
    assign sum_o  = total[SLICE_W-1:0];
    assign cout_o = total[SLICE_W];

    // XOR of the two extension bits; XOR with cout gives bit W of the widened result.
    assign ext_o  = (signed_i & a_i[SLICE_W-1]) ^ (signed_i & b_i[SLICE_W-1]) ^ sub_i;

endmodule

// File: rtl/simd_add_pipe.sv
// rtl/simd_add_pipe.sv - pipelined packed-SIMD wrap/halving/saturating add-subtract unit
module simd_add_pipe
    import vector_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  vadd_op_t        operation_i,
    input  vesize_t         esize_i,
    input  logic            signed_i,
    input  logic            sub_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic [XLEN-1:0] result_o,
    output logic            saturated_o,
    output logic            valid_o,
    input  logic            ready_i,
    input  logic            vxsat_clear_i,
    output logic            vxsat_o
);

    localparam int SW = SLICE_W;
    localparam int NS = XLEN / SW;
    localparam logic [SW-1:0] MIN_TOP = {1'b1, {(SW-1){1'b0}}};
    localparam logic [SW-1:0] MAX_TOP = ~MIN_TOP;

    logic [NS-1:0]   lane_start;
    logic [NS-1:0]   lane_top;
    logic [XLEN-1:0] slice_sum;
    logic [XLEN:0]   sum_ext;
    logic [NS-1:0]   slice_cout;
    logic [NS-1:0]   slice_ext;
    logic [XLEN-1:0] comb_res;
    logic            comb_sat;

    always_comb begin
        int span;
        span       = lane_slices(esize_i);
        lane_start = '0;
        lane_top   = '0;
        for (int i = 0; i < NS; i++) begin
            lane_start[i] = (i % span) == 0;
            lane_top[i]   = (i % span) == (span - 1);
        end
    end

    for (genvar g = 0; g < NS; g++) begin : slc
        logic cin;
        logic cout;

        if (g == 0) begin : g_first
            assign cin = sub_i;
        end else begin : g_chain
            assign cin = lane_start[g] ? sub_i : slc[g-1].cout;
        end

        simd_add_slice u_slice (
            .a_i      (operand_a_i[g*SW +: SW]),
            .b_i      (operand_b_i[g*SW +: SW]),
            .sub_i    (sub_i),
            .signed_i (signed_i),
            .cin_i    (cin),
            .sum_o    (slice_sum[g*SW +: SW]),
            .cout_o   (cout),
            .ext_o    (slice_ext[g])
        );

        assign slice_cout[g] = cout;
    end

    assign sum_ext = {1'b0, slice_sum};

    // Each slice looks up its lane's top slice for bit W and the overflow decision.
    always_comb begin
        int            span;
        int            top;
        logic          bit_w;
        logic          ovf;
        logic [SW-1:0] sum_b;
        logic [SW-1:0] hv_b;
        logic [SW-1:0] clamp_b;
        logic [SW-1:0] res_b;
        comb_res = '0;
        comb_sat = 1'b0;
        span     = lane_slices(esize_i);
        for (int i = 0; i < NS; i++) begin
            top   = i - (i % span) + span - 1;
            bit_w = slice_ext[top] ^ slice_cout[top];
            ovf   = signed_i ? (bit_w ^ slice_sum[top*SW + SW-1]) : bit_w;
            sum_b = slice_sum[i*SW +: SW];
            hv_b  = {lane_top[i] ? bit_w : sum_ext[(i+1)*SW], sum_b[SW-1:1]};
            if (signed_i) begin
                clamp_b = bit_w ? (lane_top[i] ? MIN_TOP : '0) : (lane_top[i] ? MAX_TOP : '1);
            end else begin
                clamp_b = sub_i ? '0 : '1;
            end
            unique case (operation_i)
                HV_VADD:  res_b = hv_b;
                SAT_VADD: begin
                    res_b    = ovf ? clamp_b : sum_b;
                    comb_sat = comb_sat | ovf;
                end
                default:  res_b = sum_b;
            endcase
            comb_res[i*SW +: SW] = res_b;
        end
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] sat_q, sat_d;
    logic [STAGES-1:0] load;
    logic [XLEN-1:0]   data_q [STAGES];
    logic [XLEN-1:0]   data_d [STAGES];
    logic              vxsat_q, vxsat_d;
    logic              accept;
    logic              retire;

    // Stage k loads when it or any stage behind it is empty, or the output drains.
    always_comb begin
        logic acc;
        acc  = ready_i;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | ~valid_q[k];
            load[k] = acc;
        end
    end

    assign ready_o = load[0] & ~flush_i;
    assign accept  = valid_i & ready_o;
    assign retire  = valid_o & ready_i;

    always_comb begin
        valid_d = valid_q;
        sat_d   = sat_q;
        data_d  = data_q;
        if (load[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                data_d[0] = comb_res;
                sat_d[0]  = comb_sat;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    sat_d[k]  = sat_q[k-1];
                end
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    assign vxsat_d = (retire & saturated_o) ? 1'b1 : (vxsat_clear_i ? 1'b0 : vxsat_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            sat_q   <= '0;
            vxsat_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
            vxsat_q <= vxsat_d;
        end
    end

    assign result_o    = data_q[STAGES-1];
    assign saturated_o = sat_q[STAGES-1];
    assign valid_o     = valid_q[STAGES-1];
    assign vxsat_o     = vxsat_q;

endmodule

// File: tb/tb_simd_add_pipe.sv
// tb/tb_simd_add_pipe.sv - self-checking bench for simd_add_pipe with a result scoreboard
module tb_simd_add_pipe;
    import vector_unit_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    vadd_op_t        op_i;
    vesize_t         es_i;
    logic            signed_i;
    logic            sub_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [XLEN-1:0] result_o;
    logic            saturated_o;
    logic            valid_o;
    logic            ready_i;
    logic            vxsat_clear_i;
    logic            vxsat_o;

    always #5 clk = ~clk;

    simd_add_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .operation_i   (op_i),
        .esize_i       (es_i),
        .signed_i      (signed_i),
        .sub_i         (sub_i),
        .operand_a_i   (a_i),
        .operand_b_i   (b_i),
        .result_o      (result_o),
        .saturated_o   (saturated_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .vxsat_clear_i (vxsat_clear_i),
        .vxsat_o       (vxsat_o)
    );

    typedef struct {
        vadd_op_t    op;
        vesize_t     es;
        logic        sgn;
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        sat;
    } exp_t;

    vec_t        vecs [12];
    exp_t        sb [$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] drv_res;
    logic        drv_sat;
    logic        exp_vxsat;
    logic        exp_next;
    logic        hold_q;
    logic [31:0] hold_res;
    logic        hold_sat;
    vec_t        rv;
    logic [32:0] mv;
    bit          rnd_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Independent per-lane integer reference.
    function automatic logic [32:0] model(input vadd_op_t op, input vesize_t es, input logic sgn,
                                          input logic sub, input logic [31:0] a, input logic [31:0] b);
        int          w;
        logic [31:0] res;
        logic        flag;
        longint      x, y, r, lo, hi, m;
        w    = (es == BIT8) ? 8 : (es == BIT16) ? 16 : 32;
        res  = '0;
        flag = 1'b0;
        m    = (longint'(1) << w) - 1;
        for (int l = 0; l < 32 / w; l++) begin
            x = (longint'(a) >> (l * w)) & m;
            y = (longint'(b) >> (l * w)) & m;
            if (sgn && x[w-1]) x = x - (m + 1);
            if (sgn && y[w-1]) y = y - (m + 1);
            r = sub ? x - y : x + y;
            if (op == HV_VADD) begin
                r = r >>> 1;
            end else if (op == SAT_VADD) begin
                lo = sgn ? -(longint'(1) << (w - 1)) : 0;
                hi = sgn ? (longint'(1) << (w - 1)) - 1 : m;
                if (r < lo) begin r = lo; flag = 1'b1; end
                else if (r > hi) begin r = hi; flag = 1'b1; end
            end
            res = res | (32'(r & m) << (l * w));
        end
        return {flag, res};
    endfunction

    // Scoreboard: retire/compare, then flush, then accept; vxsat tracked as a model.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_vxsat = 1'b0;
            hold_q    = 1'b0;
        end else begin
            check("vxsat", vxsat_o, exp_vxsat);
            if (hold_q && valid_o) begin
                check("hold_result", result_o, hold_res);
                check("hold_saturated", saturated_o, hold_sat);
            end
            hold_q   = valid_o && !ready_i && !flush_i;
            hold_res = result_o;
            hold_sat = saturated_o;
            exp_next = vxsat_clear_i ? 1'b0 : exp_vxsat;
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual=%0h required=none", result_o);
                end else begin
                    e = sb.pop_front();
                    check("result", result_o, e.res);
                    check("saturated", saturated_o, e.sat);
                    if (e.sat) exp_next = 1'b1;
                end
            end
            exp_vxsat = exp_next;
            if (flush_i) sb.delete();
            if (valid_i && ready_o) sb.push_back('{drv_res, drv_sat});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        op_i     = v.op;
        es_i     = v.es;
        signed_i = v.sgn;
        sub_i    = v.sub;
        a_i      = v.a;
        b_i      = v.b;
        drv_res  = v.res;
        drv_sat  = v.sat;
        valid_i  = 1'b1;
    endtask

    task automatic send(input vec_t v);
        int cyc;
        bit acc;
        cyc = 0;
        acc = 0;
        drive(v);
        while (!acc && cyc < 100) begin
            @(negedge clk);
            acc = ready_o;
            step();
            cyc++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual=not_accepted required=accepted");
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || valid_o) && cyc < 200) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; vxsat_clear_i = 1'b0;
        op_i = VADD; es_i = BIT8; signed_i = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
        drv_res = '0; drv_sat = 1'b0; rnd_done = 0;

        vecs[0]  = '{SAT_VADD, BIT8,  1'b1, 1'b0, 32'h7F8001FF, 32'h01FF0101, 32'h7F800200, 1'b1};
        vecs[1]  = '{HV_VADD,  BIT16, 1'b0, 1'b0, 32'hFFFF0003, 32'h00010004, 32'h80000003, 1'b0};
        vecs[2]  = '{HV_VADD,  BIT16, 1'b1, 1'b0, 32'h80008000, 32'h80000000, 32'h8000C000, 1'b0};
        vecs[3]  = '{VADD,     BIT32, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[4]  = '{SAT_VADD, BIT32, 1'b0, 1'b1, 32'h00000005, 32'h00000009, 32'h00000000, 1'b1};
        vecs[5]  = '{VADD,     BIT8,  1'b0, 1'b0, 32'hFFFFFFFF, 32'h01010101, 32'h00000000, 1'b0};
        vecs[6]  = '{VADD,     BIT16, 1'b0, 1'b1, 32'h00000100, 32'h00010001, 32'hFFFF00FF, 1'b0};
        vecs[7]  = '{SAT_VADD, BIT16, 1'b1, 1'b1, 32'h80007FFF, 32'h0001FFFF, 32'h80007FFF, 1'b1};
        vecs[8]  = '{SAT_VADD, BIT8,  1'b0, 1'b0, 32'hF0108001, 32'h20108001, 32'hFF20FF02, 1'b1};
        vecs[9]  = '{HV_VADD,  BIT8,  1'b1, 1'b1, 32'h0005807F, 32'h01007F80, 32'hFF02807F, 1'b0};
        vecs[10] = '{SAT_VADD, BIT32, 1'b1, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
        vecs[11] = '{SAT_VADD, BIT16, 1'b0, 1'b0, 32'h7FFF0001, 32'h80000002, 32'hFFFF0003, 1'b0};

        #12;
        check("reset_valid_o", valid_o, 1'b0);
        check("reset_result_o", result_o, 32'h0);
        check("reset_saturated_o", saturated_o, 1'b0);
        check("reset_vxsat_o", vxsat_o, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("ready_after_reset", ready_o, 1'b1);

        // Table vectors back to back at full throughput.
        for (int i = 0; i < 12; i++) send(vecs[i]);
        valid_i = 1'b0;
        drain();

        // Back-pressure fills the two-stage pipe; payload must hold.
        ready_i = 1'b0;
        send(vecs[1]);
        send(vecs[2]);
        drive(vecs[3]);
        @(negedge clk);
        check("full_ready_o", ready_o, 1'b0);
        check("full_valid_o", valid_o, 1'b1);
        check("full_result_o", result_o, vecs[1].res);
        step();
        ready_i = 1'b1;
        send(vecs[3]);
        send(vecs[5]);
        valid_i = 1'b0;
        drain();

        // Flush with two ops in flight and a new op offered.
        ready_i = 1'b0;
        send(vecs[8]);
        send(vecs[4]);
        drive(vecs[6]);
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_ready_o", ready_o, 1'b0);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        check("flush_valid_o", valid_o, 1'b0);
        check("flush_vxsat_o", vxsat_o, exp_vxsat);
        step();
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_flush_valid_o", valid_o, 1'b0);
            step();
        end

        // Clear vs. saturating retirement in the same cycle.
        vxsat_clear_i = 1'b1;
        step();
        vxsat_clear_i = 1'b0;
        ready_i = 1'b0;
        send(vecs[0]);
        valid_i = 1'b0;
        for (int i = 0; i < 10 && !valid_o; i++) step();
        check("sat_op_waiting", valid_o, 1'b1);
        ready_i = 1'b1;
        vxsat_clear_i = 1'b1;
        step();
        vxsat_clear_i = 1'b0;
        @(negedge clk);
        check("vxsat_set_wins", vxsat_o, 1'b1);
        step();
        vxsat_clear_i = 1'b1;
        step();
        vxsat_clear_i = 1'b0;
        @(negedge clk);
        check("vxsat_clear", vxsat_o, 1'b0);
        step();

        // Asynchronous reset mid-stream.
        send(vecs[7]);
        valid_i = 1'b0;
        drain();
        ready_i = 1'b0;
        send(vecs[8]);
        send(vecs[0]);
        valid_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async_valid_o", valid_o, 1'b0);
        check("async_result_o", result_o, 32'h0);
        check("async_saturated_o", saturated_o, 1'b0);
        check("async_vxsat_o", vxsat_o, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        ready_i = 1'b1;
        step();
        check("ready_after_midreset", ready_o, 1'b1);

        // Random ops against the model with random back-pressure and clears.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rv.op  = vadd_op_t'($urandom_range(0, 2));
                    rv.es  = vesize_t'($urandom_range(0, 2));
                    rv.sgn = 1'($urandom_range(0, 1));
                    rv.sub = 1'($urandom_range(0, 1));
                    rv.a   = $urandom;
                    rv.b   = $urandom;
                    mv     = model(rv.op, rv.es, rv.sgn, rv.sub, rv.a, rv.b);
                    rv.res = mv[31:0];
                    rv.sat = mv[32];
                    send(rv);
                end
                valid_i  = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    ready_i       = 1'($urandom_range(0, 1));
                    vxsat_clear_i = ($urandom_range(0, 7) == 0);
                end
            end
        join
        ready_i = 1'b1;
        vxsat_clear_i = 1'b0;
        drain();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
